pueo_scaler_bank: RTL and testbench
===================================

PUEO_SCALER_BANK -- requirements
Module: pueo_scaler_bank

Interface
REQ-001 Parameter NCHAN, default 32, number of trigger channels (legal 1..64).
REQ-002 Parameter CNT_W, default 16, counter/readout width in bits (legal 8..32).
REQ-003 Derived ADR_W = max(1, clog2(NCHAN)); not user-settable.
REQ-004 sysclk_i  in  1  sole clock; all logic on rising edge.
REQ-005 sysrst_n_i  in  1  asynchronous active-low reset.
REQ-006 pps_i  in  1  period strobe, one-cycle pulse, sysclk_i domain.
REQ-007 gate_i  in  1  global gate level.
REQ-008 gate_en_i  in  NCHAN  per-channel gate enable; 0 = channel ungated (always counts).
REQ-009 trig_i  in  NCHAN  per-channel trigger levels, synchronous to sysclk_i.
REQ-010 prescale_i  in  4  log2 prescale factor, shared by all channels (present only with SCALER_PRESCALE_EN).
REQ-011 rd_adr_i  in  ADR_W  readout channel address.
REQ-012 rd_dat_o  out  CNT_W  readout data, registered.
REQ-013 update_o  out  1  one-cycle pulse: new period's data now readable.
REQ-014 seq_o  out  8  count of completed bank swaps, wraps 255->0.
REQ-015 overrun_o  out  1  one-cycle pulse: pps_i arrived while a copy was in progress.

Function
REQ-016 Edge: channel i sees an event on a cycle where trig_i[i]=1, trig_i[i] was 0 the previous cycle, and (gate_i | ~gate_en_i[i])=1.
REQ-017 Counter: each event increments the channel counter by 1; at all-ones the counter holds (saturates), never wraps.
REQ-018 On a pps_i cycle, counter value (before that cycle's event) loads into the channel hold register; counter loads 1 if an event occurs the same cycle, else 0.
REQ-019 Copy FSM states IDLE, COPY, SWAP: IDLE->COPY on pps_i; COPY writes hold[k] to the inactive bank for k=0..NCHAN-1, one per cycle; COPY->SWAP after k=NCHAN-1; SWAP->IDLE after one cycle.
REQ-020 SWAP cycle: active bank toggles, update_o=1, seq_o increments; data visible from the next read cycle.
REQ-021 Total latency pps_i to update_o = NCHAN+2 cycles.
REQ-022 pps_i while in COPY or SWAP: counters still snapshot/clear per REQ-018 except hold registers do NOT reload; overrun_o pulses; copy continues unaffected; that period's data is lost.
REQ-023 Readout: rd_dat_o = active_bank[rd_adr_i], one-cycle latency; rd_adr_i >= NCHAN returns 0.
REQ-024 Read of the active bank is never disturbed by copy writes (writes target only the inactive bank).

Reset
REQ-025 sysrst_n_i low: counters, hold registers, both banks, edge history, prescaler residues cleared; FSM IDLE; active bank 0.
REQ-026 During and after reset: rd_dat_o=0, update_o=0, seq_o=0, overrun_o=0.
REQ-027 Reset asserted mid-COPY aborts the copy; no swap occurs; first update_o after release requires a new pps_i.

Configuration
REQ-028 Macro SCALER_PRESCALE_EN defined: per-channel prescaler counts events; counter increments once per 2^prescale_i events (prescale_i=0 -> every event); residue clears on pps_i; prescale_i sampled each cycle.
REQ-029 Macro undefined: prescale_i port and prescaler logic absent; every event increments the counter.

Verification
REQ-030 NCHAN=32, CNT_W=16: 5 rising edges on trig_i[3], gate_en_i=0, then pps_i -> update_o at pps+34 cycles, rd_adr_i=3 reads 5, other channels read 0, seq_o=1.
REQ-031 gate_en_i[7]=1, gate_i=0 during 10 edges, gate_i=1 during 4 edges, pps_i -> channel 7 reads 4.
REQ-032 70000 edges on channel 0 within one period, pps_i -> reads 0xFFFF; next period with 2 edges reads 2.
REQ-033 trig_i[1] held high 100 cycles -> counts 1; edge coincident with pps_i -> counts in new period (next readout 1).
REQ-034 Second pps_i 10 cycles after first -> overrun_o pulse, first period's data delivered, seq_o=1; reset mid-COPY -> no update_o, all reads 0.
REQ-035 With SCALER_PRESCALE_EN, prescale_i=3, 20 edges, pps_i -> reads 2; without macro same stimulus reads 20.

Source files
------------

// File: rtl/pueo_scaler_bank.sv
// rtl/pueo_scaler_bank.sv - per-channel trigger scalers with double-buffered period readout
// Optional feature macro: SCALER_PRESCALE_EN (adds prescale_i and per-channel prescalers).
module pueo_scaler_bank #(
    parameter int NCHAN = 32,
    parameter int CNT_W = 16,
    localparam int ADR_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic             sysclk_i,
    input  logic             sysrst_n_i,
    input  logic             pps_i,
    input  logic             gate_i,
    input  logic [NCHAN-1:0] gate_en_i,
    input  logic [NCHAN-1:0] trig_i,
`ifdef SCALER_PRESCALE_EN
    input  logic [3:0]       prescale_i,
`endif
    input  logic [ADR_W-1:0] rd_adr_i,
    output logic [CNT_W-1:0] rd_dat_o,
    output logic             update_o,
    output logic [7:0]       seq_o,
    output logic             overrun_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_SWAP = 2'd2
    } state_t;

    localparam logic [ADR_W-1:0] K_LAST = ADR_W'(NCHAN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [ADR_W-1:0] copy_k;
    logic             act_bank;

    logic [NCHAN-1:0] trig_q;
    logic [NCHAN-1:0] evt;
    logic [NCHAN-1:0] inc;
    logic             busy;
    logic             snap;

    logic [CNT_W-1:0] cnt  [NCHAN];
    logic [CNT_W-1:0] hold [NCHAN];
    logic [CNT_W-1:0] bank [2][NCHAN];

    // An event is a gated rising edge; ungated channels ignore gate_i.
    assign evt  = trig_i & ~trig_q & ({NCHAN{gate_i}} | ~gate_en_i);
    assign busy = (state != ST_IDLE);
    assign snap = pps_i & ~busy;

    // Edge history for every trigger line.
    always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
        if (!sysrst_n_i) begin
            trig_q <= '0;
        end else begin
            trig_q <= trig_i;
        end
    end

`ifdef SCALER_PRESCALE_EN
    logic [15:0] res     [NCHAN];
    logic [15:0] res_nxt [NCHAN];
    logic [15:0] thr;

    // Prescaler: an event on the pps cycle is the first event of the new period.
    always_comb begin
        thr = 16'd1 << prescale_i;
        for (int i = 0; i < NCHAN; i++) begin
            res_nxt[i] = (pps_i ? 16'd0 : res[i]) + {15'd0, evt[i]};
            inc[i]     = 1'b0;
            if (evt[i] && (res_nxt[i] >= thr)) begin
                inc[i]     = 1'b1;
                res_nxt[i] = 16'd0;
            end
        end
    end

    // Prescaler residue registers.
    always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
        if (!sysrst_n_i) begin
            for (int i = 0; i < NCHAN; i++) begin
                res[i] <= 16'd0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                res[i] <= res_nxt[i];
            end
        end
    end
`else
    assign inc = evt;
`endif

    // Saturating counters; pps snapshots into hold (only when the copier is free) and restarts the period.
    always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
        if (!sysrst_n_i) begin
            for (int i = 0; i < NCHAN; i++) begin
                cnt[i]  <= '0;
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (pps_i) begin
                    cnt[i] <= CNT_W'(inc[i]);
                    if (snap) begin
                        hold[i] <= cnt[i];
                    end
                end else if (inc[i] && (cnt[i] != CNT_MAX)) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Copy FSM: moves hold into the inactive bank one channel per cycle, then swaps banks.
    always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
        if (!sysrst_n_i) begin
            state     <= ST_IDLE;
            copy_k    <= '0;
            act_bank  <= 1'b0;
            update_o  <= 1'b0;
            seq_o     <= 8'd0;
            overrun_o <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NCHAN; i++) begin
                    bank[b][i] <= '0;
                end
            end
        end else begin
            update_o  <= 1'b0;
            overrun_o <= pps_i & busy;
            case (state)
                ST_IDLE: begin
                    if (pps_i) begin
                        state  <= ST_COPY;
                        copy_k <= '0;
                    end
                end
                ST_COPY: begin
                    bank[~act_bank][copy_k] <= hold[copy_k];
                    if (copy_k == K_LAST) begin
                        state <= ST_SWAP;
                    end else begin
                        copy_k <= copy_k + ADR_W'(1);
                    end
                end
                ST_SWAP: begin
                    act_bank <= ~act_bank;
                    update_o <= 1'b1;
                    seq_o    <= seq_o + 8'd1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered readout of the active bank; addresses beyond the last channel read zero.
    always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
        if (!sysrst_n_i) begin
            rd_dat_o <= '0;
        end else if (32'(rd_adr_i) < 32'(NCHAN)) begin
            rd_dat_o <= bank[act_bank][rd_adr_i];
        end else begin
            rd_dat_o <= '0;
        end
    end

endmodule

// File: tb/tb_pueo_scaler_bank.sv
// tb/tb_pueo_scaler_bank.sv - self-checking bench for pueo_scaler_bank
module tb_pueo_scaler_bank;

    localparam int NCHAN   = 32;
    localparam int CNT_W   = 16;
    localparam int ADR_W   = 5;
    localparam int S_NCHAN = 3;
    localparam int S_CNT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0;
    logic             pps = 1'b0;
    logic             gate = 1'b0;
    logic [NCHAN-1:0] gate_en = '0;
    logic [NCHAN-1:0] trig = '0;
    logic [ADR_W-1:0] rd_adr = '0;
    logic [CNT_W-1:0] rd_dat;
    logic             update;
    logic [7:0]       seq;
    logic             overrun;
`ifdef SCALER_PRESCALE_EN
    logic [3:0]       prescale = 4'd0;
`endif

    logic               s_pps = 1'b0;
    logic [S_NCHAN-1:0] s_trig = '0;
    logic [S_NCHAN-1:0] s_gate_en = '0;
    logic [1:0]         s_adr = '0;
    logic [S_CNT_W-1:0] s_dat;
    logic               s_update;
    logic [7:0]         s_seq;
    logic               s_overrun;

    pueo_scaler_bank #(.NCHAN(NCHAN), .CNT_W(CNT_W)) dut (
        .sysclk_i   (clk),
        .sysrst_n_i (rst_n),
        .pps_i      (pps),
        .gate_i     (gate),
        .gate_en_i  (gate_en),
        .trig_i     (trig),
`ifdef SCALER_PRESCALE_EN
        .prescale_i (prescale),
`endif
        .rd_adr_i   (rd_adr),
        .rd_dat_o   (rd_dat),
        .update_o   (update),
        .seq_o      (seq),
        .overrun_o  (overrun)
    );

    pueo_scaler_bank #(.NCHAN(S_NCHAN), .CNT_W(S_CNT_W)) dut_s (
        .sysclk_i   (clk),
        .sysrst_n_i (rst_n),
        .pps_i      (s_pps),
        .gate_i     (1'b0),
        .gate_en_i  (s_gate_en),
        .trig_i     (s_trig),
`ifdef SCALER_PRESCALE_EN
        .prescale_i (4'd0),
`endif
        .rd_adr_i   (s_adr),
        .rd_dat_o   (s_dat),
        .update_o   (s_update),
        .seq_o      (s_seq),
        .overrun_o  (s_overrun)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (main instance) ----------------
    int cyc = 0;
    int upd_edge = -1;
    int ev_cnt [NCHAN];
    bit prev   [NCHAN];
    int snap_v [NCHAN];
    int vis    [NCHAN];
    int m_seq = 0;
    bit m_update = 0;
    bit m_overrun = 0;
    int m_rd = 0;

    function automatic int cval(input int ev);
        int p;
        int v;
        p = 0;
`ifdef SCALER_PRESCALE_EN
        p = int'(prescale);
`endif
        v = ev >> p;
        if (v > (1 << CNT_W) - 1) v = (1 << CNT_W) - 1;
        return v;
    endfunction

    always @(posedge clk) begin
        bit busy;
        bit e;
        if (!rst_n) begin
            upd_edge  = -1;
            m_seq     = 0;
            m_update  = 0;
            m_overrun = 0;
            m_rd      = 0;
            for (int c = 0; c < NCHAN; c++) begin
                ev_cnt[c] = 0; prev[c] = 0; snap_v[c] = 0; vis[c] = 0;
            end
        end else begin
            cyc++;
            m_rd      = vis[rd_adr];
            busy      = (upd_edge >= 0) && (cyc <= upd_edge);
            m_update  = (cyc == upd_edge);
            m_overrun = pps && busy;
            if (m_update) begin
                for (int c = 0; c < NCHAN; c++) vis[c] = snap_v[c];
                m_seq = (m_seq + 1) % 256;
            end
            for (int c = 0; c < NCHAN; c++) begin
                e = trig[c] && !prev[c] && (gate || !gate_en[c]);
                prev[c] = trig[c];
                if (pps) begin
                    if (!busy) snap_v[c] = cval(ev_cnt[c]);
                    ev_cnt[c] = int'(e);
                end else begin
                    ev_cnt[c] += int'(e);
                end
            end
            if (pps && !busy) upd_edge = cyc + NCHAN + 1;
        end
    end

    // Compare the main instance against the model every cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_update", update, 0);
            chk("rst_seq", seq, 0);
            chk("rst_overrun", overrun, 0);
            chk("rst_rd_dat", rd_dat, 0);
        end else begin
            chk("update", update, m_update);
            chk("seq", seq, m_seq);
            chk("overrun", overrun, m_overrun);
            chk("rd_dat", rd_dat, m_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic edges(input int ch, input int n);
        repeat (n) begin
            trig[ch] = 1'b1; step();
            trig[ch] = 1'b0; step();
        end
    endtask

    task automatic fire_pps_wait(output int lat);
        pps = 1'b1;
        lat = 0;
        do begin
            step();
            pps = 1'b0;
            lat++;
        end while (!update && lat < 200);
    endtask

    task automatic rd(input int a, input int exp, input string name);
        rd_adr = ADR_W'(a);
        step();
        chk(name, rd_dat, exp);
    endtask

    task automatic s_pps_wait(output int lat);
        s_pps = 1'b1;
        lat = 0;
        do begin
            step();
            s_pps = 1'b0;
            lat++;
        end while (!s_update && lat < 200);
    endtask

    task automatic s_edges(input int n);
        repeat (n) begin
            s_trig[0] = 1'b1; step();
            s_trig[0] = 1'b0; step();
        end
    endtask

    initial begin
        int lat;
        int upd_seen;

        step(3);
        chk("reset_rd", rd_dat, 0);
        chk("reset_seq", seq, 0);
        rst_n = 1'b1;
        step(2);

        // five edges on channel 3, ungated
        edges(3, 5);
        fire_pps_wait(lat);
        chk("latency_32", lat, 34);
        chk("seq_after_first", seq, 1);
        rd(3, 5, "ch3_count");
        rd(4, 0, "ch4_zero");
        for (int a = 0; a < NCHAN; a++) begin
            rd_adr = ADR_W'(a);
            step();
        end

        // gating on channel 7
        gate_en[7] = 1'b1;
        gate = 1'b0;
        edges(7, 10);
        gate = 1'b1;
        edges(7, 4);
        gate = 1'b0;
        fire_pps_wait(lat);
        rd(7, 4, "ch7_gated");
        rd(3, 0, "ch3_cleared");

        // level held high counts once; edge on pps goes to the new period
        trig[1] = 1'b1;
        step(100);
        trig[1] = 1'b0;
        step();
        trig[1] = 1'b1;
        fire_pps_wait(lat);
        trig[1] = 1'b0;
        rd(1, 1, "ch1_level");
        fire_pps_wait(lat);
        rd(1, 1, "ch1_pps_edge");
        chk("seq_four", seq, 4);

        // second pps during copy: overrun, first period delivered
        edges(5, 3);
        pps = 1'b1; step(); pps = 1'b0;
        step(9);
        pps = 1'b1; step(); pps = 1'b0;
        chk("overrun_pulse", overrun, 1);
        lat = 0;
        while (!update && lat < 200) begin step(); lat++; end
        chk("seq_after_overrun", seq, 5);
        rd(5, 3, "ch5_first_period");
        step(40);
        chk("no_second_update_seq", seq, 5);

        // reset during copy aborts it
        edges(6, 2);
        pps = 1'b1; step(); pps = 1'b0;
        step(5);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        upd_seen = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (update) upd_seen++;
        end
        chk("no_update_after_reset", upd_seen, 0);
        rd(6, 0, "ch6_after_reset");
        rd(5, 0, "ch5_after_reset");
        chk("seq_after_reset", seq, 0);

        // prescaler (or plain counting in the default build)
`ifdef SCALER_PRESCALE_EN
        prescale = 4'd3;
`endif
        edges(9, 20);
        fire_pps_wait(lat);
`ifdef SCALER_PRESCALE_EN
        rd(9, 2, "ch9_prescaled");
        prescale = 4'd0;
`else
        rd(9, 20, "ch9_unprescaled");
`endif

        // saturation and out-of-range address on the small instance
        s_edges(300);
        s_pps_wait(lat);
        chk("s_latency", lat, 5);
        s_adr = 2'd0; step();
        chk("s_saturated", s_dat, 255);
        s_adr = 2'd3; step();
        chk("s_out_of_range", s_dat, 0);
        s_edges(2);
        s_pps_wait(lat);
        s_adr = 2'd0; step();
        chk("s_after_sat", s_dat, 2);
        chk("s_seq", s_seq, 2);

        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
